ib_vnu_pipe_ctrl: RTL and testbench
===================================

# ib_vnu_pipe_ctrl

Sequencing controller for the IB variable-node datapath: the f0/f1 decomposed-LUT cascade, its c2v pipeline registers and the pipeOut v2c source multiplexer. It counts layers and iterations, drives the pipeOut `v2c_src` select so iteration 0 bypasses channel LLRs, and tracks per-stage valids through the `PIPELINE_DEPTH`-deep pipeline. On the final iteration it switches the pass to the decision node and flags hard-decision outputs. It sits between the layer scheduler / message RAM read side and the VNU array.

## Interface
Parameters:
- `PIPELINE_DEPTH`, default 3: VNU pipeline stages. Must match the c2v pipeline modules. Minimum 2.
- `LAYER_NUM`, default 4: layers (beats) per iteration. Minimum 1.
- `MAX_ITER`, default 5: total iterations including the decision iteration. Minimum 2.
- `LAYER_W`, default 2: width of `layer_id`. Must satisfy 2^LAYER_W ≥ LAYER_NUM.
- `ITER_W`, default 4: width of `iter_cnt`. Must satisfy 2^ITER_W ≥ MAX_ITER.

Ports:
- `read_clk`, in, 1: the only clock. Reset is synchronous and active-low.
- `rstn`, in, 1: synchronous active-low reset, sampled on the `read_clk` rising edge.
- `start`, in, 1: decode request. Honoured only in IDLE.
- `c2v_valid`, in, 1: one layer's c2v/channel messages are presented to the datapath this cycle (one beat).
- `syndrome_zero`, in, 1: parity-check pass indication. Present only with `IB_EARLY_TERM_EN`.
- `v2c_src`, out, 1: pipeOut select. 1 means the channel LLR is bypassed.
- `dnu_en`, out, 1: the current beat is routed to the decision node.
- `stage_valid`, out, PIPELINE_DEPTH: per-stage valid. Bit 0 is the first stage.
- `v2c_valid`, out, 1: the pipeline tail holds a v2c message.
- `hard_dec_valid`, out, 1: the pipeline tail holds a decision-node output.
- `layer_id`, out, LAYER_W: layer index of the next accepted beat.
- `iter_cnt`, out, ITER_W: current iteration, starting at 0.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: accepts beats.
  - FLUSH: drains the pipeline.
  - DONE: one cycle, then IDLE.
- IDLE→RUN: `start`=1. On this transition `layer_id` and `iter_cnt` are cleared and `last_iter` is cleared.
- Beat accept: `acc = (state==RUN) & c2v_valid`. `c2v_valid` is ignored in IDLE, FLUSH and DONE. `start` is ignored when not in IDLE.
- On `acc`:
  - If `layer_id == LAYER_NUM-1`: `layer_id` wraps to 0 and `iter_cnt` increments.
  - Otherwise `layer_id` increments.
- RUN→FLUSH: `acc` on the final layer of the decision iteration. `iter_cnt` increments on this beat too, ending at `MAX_ITER`.
- Decision iteration: `iter_cnt == MAX_ITER-1`, or `last_iter` is set.
- Combinational outputs:
  - `v2c_src = (iter_cnt == 0)`.
  - `dnu_en = (state==RUN) & decision iteration`.
- Pipeline tracking:
  - `stage_valid[0] <= acc`; `stage_valid[i] <= stage_valid[i-1]`.
  - A parallel tag shift register carries `dnu_en`: `tag[0] <= acc & dnu_en`.
  - `v2c_valid = stage_valid[D-1] & ~tag[D-1]`.
  - `hard_dec_valid = stage_valid[D-1] & tag[D-1]`.
- FLUSH→DONE: `stage_valid` is all zeros.
- DONE: `done`=1 for one cycle, then IDLE. `iter_cnt` holds its final value until the next `start`.
- Simultaneous events: `start` arriving in DONE is ignored. Back-to-back decodes therefore need at least one IDLE cycle.
- Reset mid-operation: the next edge clears all state, counters and shift registers. In-flight pipeline contents are abandoned and no `done` is issued.

## Timing
- Reset values:
  - State IDLE.
  - `layer_id`=0, `iter_cnt`=0, therefore `v2c_src`=1.
  - `dnu_en`=0, `stage_valid`=0, `v2c_valid`=0, `hard_dec_valid`=0.
  - `busy`=0, `done`=0.
- `start` sampled at edge t gives `busy`=1 from cycle t+1.
- Beat-to-tail latency is exactly PIPELINE_DEPTH cycles: a beat accepted at edge t is at the pipeline tail in cycle t+PIPELINE_DEPTH.
- The final beat accepted at edge t gives `done`=1 in cycle t+PIPELINE_DEPTH+1 and `busy`=0 in cycle t+PIPELINE_DEPTH+2.
- `layer_id`, `iter_cnt` and `v2c_src` change only on an accept edge.
- Gaps in `c2v_valid` stall counting with no loss.

## Configuration
- `IB_EARLY_TERM_EN` defined:
  - `syndrome_zero` is sampled on `acc` with `layer_id == LAYER_NUM-1` and `iter_cnt ≥ 1`.
  - If it is 1, `last_iter` is set and the next iteration becomes the decision iteration, regardless of `iter_cnt`.
  - `last_iter` is not set when that beat is already part of the decision iteration.
- `IB_EARLY_TERM_EN` undefined:
  - The `syndrome_zero` port is absent.
  - `last_iter` is tied to 0.
  - Exactly `MAX_ITER` iterations always run.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles → all outputs at their reset values and `v2c_src`=1.
- Defaults (4 layers, 5 iterations, depth 3), `start` then `c2v_valid` held at 1 → 20 accepts in total:
  - `v2c_src`=1 for the first 4 accepts only.
  - `dnu_en`=1 on accepts 17–20.
  - 16 `v2c_valid` pulses, then 4 `hard_dec_valid` pulses.
  - `done` 4 cycles after the 20th accept.
- `c2v_valid` toggling 1,0,1,0 → `layer_id` advances only on the high cycles, and `stage_valid[2]` reproduces the pattern 3 cycles later.
- `rstn`=0 after the 7th accept → next cycle IDLE with `stage_valid`=0. `done` never pulses. A new `start` runs a full decode.
- `start` asserted during RUN and again during DONE → ignored. `iter_cnt` is unaffected.
- `IB_EARLY_TERM_EN` defined, `syndrome_zero`=1 at the end of iteration 1 → iteration 2 is the decision iteration. `done` follows 12 accepts plus 4 cycles.

Source files
------------

// File: rtl/ib_vnu_pipe_ctrl_if.sv
// rtl/ib_vnu_pipe_ctrl_if.sv - VNU datapath-side signal bundle for ib_vnu_pipe_ctrl
//
// Purpose: groups the beat input and the per-beat datapath controls that run
// between the pipe controller and the VNU array / pipeOut mux.
// Signals:
//   c2v_valid      - one layer of c2v/channel messages presented this cycle
//   v2c_src        - pipeOut select, 1 = channel LLR bypassed
//   dnu_en         - current beat is routed to the decision node
//   stage_valid    - per-stage valid, bit 0 is the first VNU stage
//   v2c_valid      - pipeline tail holds a v2c message
//   hard_dec_valid - pipeline tail holds a decision-node output
// Modports: master = controller side, slave = datapath / beat source side.

interface ib_vnu_pipe_ctrl_if #(
  parameter int PIPELINE_DEPTH = 3
);
  logic                      c2v_valid;
  logic                      v2c_src;
  logic                      dnu_en;
  logic [PIPELINE_DEPTH-1:0] stage_valid;
  logic                      v2c_valid;
  logic                      hard_dec_valid;

  modport master (
    input  c2v_valid,
    output v2c_src,
    output dnu_en,
    output stage_valid,
    output v2c_valid,
    output hard_dec_valid
  );

  modport slave (
    output c2v_valid,
    input  v2c_src,
    input  dnu_en,
    input  stage_valid,
    input  v2c_valid,
    input  hard_dec_valid
  );
endinterface

// File: rtl/ib_vnu_pipe_ctrl.sv
// rtl/ib_vnu_pipe_ctrl.sv - layer/iteration sequencer and pipeline valid tracker for the IB VNU
//
// Purpose: counts layers and iterations of an IB decode, drives the pipeOut
// v2c source select, routes the decision iteration to the decision node and
// tracks per-stage valids (plus a decision tag) through the VNU pipeline.
// Optional feature macro: IB_EARLY_TERM_EN (adds syndrome_zero early termination).
// Ports:
//   read_clk      - clock
//   rstn          - synchronous active-low reset
//   start         - decode request, honoured only in IDLE
//   syndrome_zero - parity-check pass (only with IB_EARLY_TERM_EN)
//   vnu           - datapath bundle (ib_vnu_pipe_ctrl_if.master)
//   layer_id      - layer index of the next accepted beat
//   iter_cnt      - current iteration, from 0
//   busy          - controller not idle
//   done          - one-cycle completion pulse

module ib_vnu_pipe_ctrl #(
  parameter int PIPELINE_DEPTH = 3,
  parameter int LAYER_NUM      = 4,
  parameter int MAX_ITER       = 5,
  parameter int LAYER_W        = 2,
  parameter int ITER_W         = 4
) (
  input  logic                read_clk,
  input  logic                rstn,
  input  logic                start,
`ifdef IB_EARLY_TERM_EN
  input  logic                syndrome_zero,
`endif
  ib_vnu_pipe_ctrl_if.master  vnu,
  output logic [LAYER_W-1:0]  layer_id,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic                busy,
  output logic                done
);

  localparam int                 D          = PIPELINE_DEPTH;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
  localparam logic [ITER_W-1:0]  DEC_ITER   = ITER_W'(MAX_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t         state;
  logic [D-1:0]   stage_valid;
  logic [D-1:0]   tag;
  logic           last_iter;
  logic           acc;
  logic           last_layer;
  logic           dec_iter;
  logic           final_beat;

  assign acc        = (state == S_RUN) & vnu.c2v_valid;
  assign last_layer = (layer_id == LAST_LAYER);
  assign dec_iter   = (iter_cnt == DEC_ITER) | last_iter;
  assign final_beat = acc & last_layer & dec_iter;

  assign vnu.v2c_src        = (iter_cnt == '0);
  assign vnu.dnu_en         = (state == S_RUN) & dec_iter;
  assign vnu.stage_valid    = stage_valid;
  assign vnu.v2c_valid      = stage_valid[D-1] & ~tag[D-1];
  assign vnu.hard_dec_valid = stage_valid[D-1] & tag[D-1];

  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      layer_id    <= '0;
      iter_cnt    <= '0;
      stage_valid <= '0;
      tag         <= '0;
    end else begin
      stage_valid <= {stage_valid[D-2:0], acc};
      tag         <= {tag[D-2:0], acc & vnu.dnu_en};

      // The final beat also bumps iter_cnt, so it rests at the iteration count run.
      if (acc) begin
        if (last_layer) begin
          layer_id <= '0;
          iter_cnt <= iter_cnt + 1'b1;
        end else begin
          layer_id <= layer_id + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            layer_id <= '0;
            iter_cnt <= '0;
          end
        end
        S_RUN: begin
          if (final_beat) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // No beats enter during FLUSH, so once every stage ahead of the tail
          // is empty the pipeline is empty after this edge; done then lines up
          // with the cycle following the last tail beat.
          if (stage_valid[D-2:0] == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IB_EARLY_TERM_EN
  // A passing syndrome at the end of iteration >= 1 promotes the following
  // iteration to the decision pass; a beat already in the decision pass
  // cannot extend or re-arm it.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      last_iter <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      last_iter <= 1'b0;
    end else if (acc && last_layer && (iter_cnt != '0) && !dec_iter && syndrome_zero) begin
      last_iter <= 1'b1;
    end
  end
`else
  assign last_iter = 1'b0;
`endif

endmodule

// File: tb/tb_ib_vnu_pipe_ctrl.sv
// tb/tb_ib_vnu_pipe_ctrl.sv - self-checking bench for ib_vnu_pipe_ctrl

module tb_ib_vnu_pipe_ctrl;
  localparam int D  = 3;
  localparam int L  = 4;
  localparam int MI = 5;
  localparam int LW = 2;
  localparam int IW = 4;

  logic          read_clk = 1'b0;
  logic          rstn;
  logic          start;
`ifdef IB_EARLY_TERM_EN
  logic          syndrome_zero;
`endif
  logic [LW-1:0] layer_id;
  logic [IW-1:0] iter_cnt;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  ib_vnu_pipe_ctrl_if #(.PIPELINE_DEPTH(D)) vnu ();

  ib_vnu_pipe_ctrl #(
    .PIPELINE_DEPTH(D),
    .LAYER_NUM(L),
    .MAX_ITER(MI),
    .LAYER_W(LW),
    .ITER_W(IW)
  ) dut (
    .read_clk(read_clk),
    .rstn(rstn),
    .start(start),
`ifdef IB_EARLY_TERM_EN
    .syndrome_zero(syndrome_zero),
`endif
    .vnu(vnu),
    .layer_id(layer_id),
    .iter_cnt(iter_cnt),
    .busy(busy),
    .done(done)
  );

  always #5 read_clk = ~read_clk;

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0;
    vnu.c2v_valid = 1'b1;
`ifdef IB_EARLY_TERM_EN
    syndrome_zero = 1'b0;
`endif
    repeat (2) @(posedge read_clk);
    @(negedge read_clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done got %b exp 00", {busy, done});
    end
    checks++;
    if ({layer_id, iter_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters got layer %0d iter %0d exp 0 0", layer_id, iter_cnt);
    end
    checks++;
    if ({vnu.v2c_src, vnu.dnu_en} !== 2'b10) begin
      errors++;
      $display("FAIL reset_src_dnu got %b exp 10", {vnu.v2c_src, vnu.dnu_en});
    end
    checks++;
    if ({vnu.stage_valid, vnu.v2c_valid, vnu.hard_dec_valid} !== '0) begin
      errors++;
      $display("FAIL reset_pipe got sv %b v2c %b hd %b exp 0", vnu.stage_valid,
               vnu.v2c_valid, vnu.hard_dec_valid);
    end
    rstn = 1'b1;
    vnu.c2v_valid = 1'b0;
  endtask

  // One full decode against a model built from accept counts:
  // accept n belongs to layer n%L of iteration n/L, reaches the tail D cycles
  // after its accept edge, and done follows the last accept by D+1 cycles.
  // mode: 0 = c2v held high, 1 = 1,0,1,0 toggle, 2 = random gaps.
  task automatic run_decode(input string name, input int mode, input int early_iter,
                            input bit poke_start);
    bit          acc_at [512];
    bit          dnu_at [512];
    int          acc_cnt;
    int          t_last;
    int          iters;
    int          total;
    bit          finished;
    bit          c;
    logic [D-1:0] exp_sv;
    bit          tail_tag;
    int          it;

    for (int i = 0; i < 512; i++) begin
      acc_at[i] = 1'b0;
      dnu_at[i] = 1'b0;
    end
    iters    = (early_iter >= 1 && early_iter < MI - 1) ? early_iter + 2 : MI;
    total    = iters * L;
    acc_cnt  = 0;
    t_last   = 100000;
    finished = 1'b0;

    @(negedge read_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_busy got %b exp 0", name, busy);
    end
    start = 1'b1;
    vnu.c2v_valid = 1'b1;   // must be ignored while still IDLE
    @(posedge read_clk);

    for (int e = 1; e <= 500; e++) begin
      @(negedge read_clk);
      it = acc_cnt / L;
      for (int i = 0; i < D; i++) exp_sv[i] = (e - 1 - i >= 1) ? acc_at[e-1-i] : 1'b0;
      tail_tag = (e - D >= 1) ? dnu_at[e-D] : 1'b0;

      checks++;
      if (layer_id !== LW'(acc_cnt % L)) begin
        errors++;
        $display("FAIL %s layer_id cyc %0d got %0d exp %0d", name, e, layer_id, acc_cnt % L);
      end
      checks++;
      if (iter_cnt !== IW'(it)) begin
        errors++;
        $display("FAIL %s iter_cnt cyc %0d got %0d exp %0d", name, e, iter_cnt, it);
      end
      checks++;
      if (vnu.v2c_src !== (it == 0)) begin
        errors++;
        $display("FAIL %s v2c_src cyc %0d got %b exp %b", name, e, vnu.v2c_src, it == 0);
      end
      checks++;
      if (vnu.dnu_en !== (acc_cnt < total && it == iters - 1)) begin
        errors++;
        $display("FAIL %s dnu_en cyc %0d got %b exp %b", name, e, vnu.dnu_en,
                 acc_cnt < total && it == iters - 1);
      end
      checks++;
      if (vnu.stage_valid !== exp_sv) begin
        errors++;
        $display("FAIL %s stage_valid cyc %0d got %b exp %b", name, e, vnu.stage_valid, exp_sv);
      end
      checks++;
      if ({vnu.v2c_valid, vnu.hard_dec_valid} !== {exp_sv[D-1] & ~tail_tag, exp_sv[D-1] & tail_tag}) begin
        errors++;
        $display("FAIL %s tail cyc %0d got v2c %b hd %b exp v2c %b hd %b", name, e,
                 vnu.v2c_valid, vnu.hard_dec_valid, exp_sv[D-1] & ~tail_tag, exp_sv[D-1] & tail_tag);
      end
      checks++;
      if (done !== (e == t_last + D + 1)) begin
        errors++;
        $display("FAIL %s done cyc %0d got %b exp %b", name, e, done, e == t_last + D + 1);
      end
      checks++;
      if (busy !== (e < t_last + D + 2)) begin
        errors++;
        $display("FAIL %s busy cyc %0d got %b exp %b", name, e, busy, e < t_last + D + 2);
      end

      if (e == t_last + D + 2) begin
        finished = 1'b1;
        break;
      end

      // start is always ignored here: RUN, FLUSH or DONE
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke_start && e == t_last + D + 1) start = 1'b1;
      case (mode)
        0:       c = 1'b1;
        1:       c = (e % 2 == 1);
        default: c = ($urandom_range(0, 99) < 60);
      endcase
      vnu.c2v_valid = c;
`ifdef IB_EARLY_TERM_EN
      if (acc_cnt % L == L - 1)
        syndrome_zero = (it == early_iter) ||
                        ((it == 0 || it == iters - 1) && $urandom_range(0, 1) == 1);
      else
        syndrome_zero = 1'($urandom_range(0, 1));
`endif
      @(posedge read_clk);
      if (c && acc_cnt < total) begin
        acc_at[e] = 1'b1;
        dnu_at[e] = (acc_cnt / L == iters - 1);
        acc_cnt++;
        if (acc_cnt == total) t_last = e;
      end
    end

    start = 1'b0;
    vnu.c2v_valid = 1'b0;
`ifdef IB_EARLY_TERM_EN
    syndrome_zero = 1'b0;
`endif
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout accepts %0d exp %0d", name, acc_cnt, total);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge read_clk);
    start = 1'b1;
    vnu.c2v_valid = 1'b0;
    @(posedge read_clk);
    @(negedge read_clk);
    start = 1'b0;
    vnu.c2v_valid = 1'b1;
    repeat (7) @(posedge read_clk);
    @(negedge read_clk);
    checks++;
    if ({iter_cnt, layer_id} !== {IW'(1), LW'(3)}) begin
      errors++;
      $display("FAIL mid_pre_reset got iter %0d layer %0d exp 1 3", iter_cnt, layer_id);
    end
    rstn = 1'b0;
    @(posedge read_clk);
    @(negedge read_clk);
    checks++;
    if ({busy, vnu.stage_valid, layer_id, iter_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset_state got busy %b sv %b layer %0d iter %0d exp all 0",
               busy, vnu.stage_valid, layer_id, iter_cnt);
    end
    checks++;
    if (vnu.v2c_src !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_src got %b exp 1", vnu.v2c_src);
    end
    rstn = 1'b1;
    for (int i = 0; i < D + 3; i++) begin
      @(posedge read_clk);
      @(negedge read_clk);
      checks++;
      if ({done, busy, vnu.stage_valid, vnu.v2c_valid, vnu.hard_dec_valid} !== '0) begin
        errors++;
        $display("FAIL mid_reset_quiet got done %b busy %b sv %b exp 0", done, busy,
                 vnu.stage_valid);
      end
    end
    vnu.c2v_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    run_decode("full", 0, -1, 1'b0);
    run_decode("toggle", 1, -1, 1'b0);
    test_reset_mid();
    run_decode("after_rst", 0, -1, 1'b0);
    run_decode("start_poke", 2, -1, 1'b1);
`ifdef IB_EARLY_TERM_EN
    run_decode("early_it1", 0, 1, 1'b0);
    run_decode("early_it2", 2, 2, 1'b1);
`endif
    for (int k = 0; k < 3; k++) run_decode("random", 2, -1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
